// File: rtl/counter_pkg.sv
// Shared direction/mode types for the step counter.
package counter_pkg;
  typedef enum logic { UP = 1'b0, DOWN = 1'b1 } dir_e;
  typedef enum logic { WRAP = 1'b0, SAT = 1'b1 } mode_e;
endpackage

// File: rtl/mod_step_next.sv
// Combinational next-count and wrap/saturation event for one step.
// Latency: 0 (pure logic); no backpressure.
module mod_step_next
  import counter_pkg::*;
#(
  parameter int N   = 4,
  parameter int MAX = 2**N - 1,
  parameter int SW  = 2
) (
  input  logic [N-1:0]  cur,
  input  dir_e          dir,
  input  mode_e         mode,
  input  logic [SW-1:0] step,
  output logic [N-1:0]  nxt,
  output logic          wrapped
);
  // One extra bit so MAX+1 == 2**N and cur+step never overflow.
  localparam logic [N:0] MAX_W = (N+1)'(MAX);
  localparam logic [N:0] MOD_W = (N+1)'(MAX + 1);

  logic [N:0] cur_w;
  logic [N:0] stp_w;
  logic [N:0] stp_eff;
  logic [N:0] sum;
  logic [N:0] dif;

  always_comb begin
    cur_w   = {1'b0, cur};
    stp_w   = (N+1)'(step);
    stp_eff = stp_w;
    // Oversized steps fold back so a wrap-mode step crosses the bound at most once.
    if (mode == WRAP && stp_w > MOD_W) begin
      stp_eff = stp_w % MOD_W;
    end
    sum     = cur_w + stp_eff;
    dif     = cur_w + MOD_W - stp_eff;
    nxt     = cur;
    wrapped = 1'b0;
    if (dir == UP) begin
      if (sum > MAX_W) begin
        wrapped = 1'b1;
        nxt     = (mode == SAT) ? MAX_W[N-1:0] : N'(sum - MOD_W);
      end else begin
        nxt = sum[N-1:0];
      end
    end else begin
      if (stp_eff > cur_w) begin
        wrapped = 1'b1;
        nxt     = (mode == SAT) ? '0 : dif[N-1:0];
      end else begin
        nxt = N'(cur_w - stp_eff);
      end
    end
  end
endmodule

// File: rtl/step_counter.sv
// Up/down step counter with wrap or saturate mode and a one-cycle wrap pulse.
// Latency: 1 cycle from sampled inputs to out/wrap; no backpressure, accepts every cycle.
module step_counter
  import counter_pkg::*;
#(
  parameter int N   = 4,
  parameter int MAX = 2**N - 1,
  parameter int SW  = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          en,
  input  logic          down,
  input  logic [SW-1:0] step,
  input  logic          sat,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  out,
  output logic          wrap,
  output logic          at_max,
  output logic          at_min
);
  localparam logic [N-1:0] MAX_N = N'(MAX);

  logic [N-1:0] nxt;
  logic         wrapped;

  mod_step_next #(
    .N   (N),
    .MAX (MAX),
    .SW  (SW)
  ) u_next (
    .cur     (out),
    .dir     (dir_e'(down)),
    .mode    (mode_e'(sat)),
    .step    (step),
    .nxt     (nxt),
    .wrapped (wrapped)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      out  <= (load_val > MAX_N) ? MAX_N : load_val;
      wrap <= 1'b0;
    end else if (en) begin
      out  <= nxt;
      wrap <= wrapped;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign at_max = (out == MAX_N);
  assign at_min = (out == '0);
endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: directed scenarios plus randomized run against an arithmetic model.
module tb_step_counter;
  localparam int MAXV = 9;
  localparam int MODV = MAXV + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst, en, down, sat, load;
  logic [1:0] step;
  logic [3:0] load_val, out;
  logic       wrap, at_max, at_min;

  logic       nrst_d, en_d, down_d, sat_d, load_d;
  logic [1:0] step_d;
  logic [3:0] load_val_d, out_d;
  logic       wrap_d, at_max_d, at_min_d;

  step_counter #(.N(4), .MAX(MAXV), .SW(2)) dut (
    .clk(clk), .nrst(nrst), .en(en), .down(down), .step(step), .sat(sat),
    .load(load), .load_val(load_val), .out(out), .wrap(wrap),
    .at_max(at_max), .at_min(at_min)
  );

  step_counter dut_def (
    .clk(clk), .nrst(nrst_d), .en(en_d), .down(down_d), .step(step_d), .sat(sat_d),
    .load(load_d), .load_val(load_val_d), .out(out_d), .wrap(wrap_d),
    .at_max(at_max_d), .at_min(at_min_d)
  );

  int ncmp = 0;
  int nerr = 0;
  int m_out = 0;
  bit m_wrap = 1'b0;

  // Reference: signed integer target, then clamp (sat) or fold modulo MAX+1 (wrap).
  task automatic model_edge();
    int s, t;
    if (!nrst) begin
      m_out = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_out = (int'(load_val) > MAXV) ? MAXV : int'(load_val); m_wrap = 1'b0;
    end else if (en) begin
      s = int'(step);
      if (!sat && s > MODV) s = s % MODV;
      t = down ? m_out - s : m_out + s;
      if (sat) begin
        m_wrap = (t > MAXV) || (t < 0);
        m_out  = (t > MAXV) ? MAXV : (t < 0) ? 0 : t;
      end else begin
        m_wrap = (t < 0) || (t >= MODV);
        m_out  = ((t % MODV) + MODV) % MODV;
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b1; step = 2'd1;
    cyc();
    ncmp++; if (out !== 4'd0) begin nerr++; $display("FAIL reset_out: got %0d want 0", out); end
    ncmp++; if (wrap !== 1'b0) begin nerr++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    ncmp++; if (at_min !== 1'b1) begin nerr++; $display("FAIL reset_at_min: got %b want 1", at_min); end
    ncmp++; if (at_max !== 1'b0) begin nerr++; $display("FAIL reset_at_max: got %b want 0", at_max); end
    nrst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_wrap_up();
    load = 1'b1; load_val = 4'd8; cyc();
    load = 1'b0; en = 1'b1; down = 1'b0; step = 2'd3; sat = 1'b0;
    cyc();
    ncmp++; if (out !== 4'd1 || wrap !== 1'b1) begin nerr++; $display("FAIL wrap_up_1: got out=%0d wrap=%b want out=1 wrap=1", out, wrap); end
    cyc();
    ncmp++; if (out !== 4'd4 || wrap !== 1'b0) begin nerr++; $display("FAIL wrap_up_2: got out=%0d wrap=%b want out=4 wrap=0", out, wrap); end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    load = 1'b1; load_val = 4'd1; cyc();
    load = 1'b0; en = 1'b1; down = 1'b1; step = 2'd2; sat = 1'b0;
    cyc();
    ncmp++; if (out !== 4'd9 || wrap !== 1'b1) begin nerr++; $display("FAIL wrap_down_1: got out=%0d wrap=%b want out=9 wrap=1", out, wrap); end
    cyc();
    ncmp++; if (out !== 4'd7 || wrap !== 1'b0) begin nerr++; $display("FAIL wrap_down_2: got out=%0d wrap=%b want out=7 wrap=0", out, wrap); end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; load_val = 4'd8; cyc();
    load = 1'b0; en = 1'b1; down = 1'b0; step = 2'd3; sat = 1'b1;
    cyc();
    ncmp++; if (out !== 4'd9 || wrap !== 1'b1) begin nerr++; $display("FAIL sat_1: got out=%0d wrap=%b want out=9 wrap=1", out, wrap); end
    cyc();
    ncmp++; if (out !== 4'd9 || wrap !== 1'b1) begin nerr++; $display("FAIL sat_sticky: got out=%0d wrap=%b want out=9 wrap=1", out, wrap); end
    ncmp++; if (at_max !== 1'b1) begin nerr++; $display("FAIL sat_at_max: got %b want 1", at_max); end
    en = 1'b0;
    cyc();
    ncmp++; if (out !== 4'd9 || wrap !== 1'b0) begin nerr++; $display("FAIL sat_hold: got out=%0d wrap=%b want out=9 wrap=0", out, wrap); end
    load = 1'b1; load_val = 4'd1; cyc();
    load = 1'b0; en = 1'b1; down = 1'b1; step = 2'd3;
    cyc();
    ncmp++; if (out !== 4'd0 || wrap !== 1'b1 || at_min !== 1'b1) begin nerr++; $display("FAIL sat_min: got out=%0d wrap=%b at_min=%b want 0 1 1", out, wrap, at_min); end
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 4'd15; en = 1'b1; down = 1'b0; step = 2'd3;
    cyc();
    ncmp++; if (out !== 4'd9 || wrap !== 1'b0) begin nerr++; $display("FAIL prio_load: got out=%0d wrap=%b want out=9 wrap=0", out, wrap); end
    nrst = 1'b0; load_val = 4'd4;
    cyc();
    ncmp++; if (out !== 4'd0) begin nerr++; $display("FAIL prio_reset: got %0d want 0", out); end
    nrst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_step_zero();
    load = 1'b1; load_val = 4'd5; cyc();
    load = 1'b0; en = 1'b1; step = 2'd0; down = 1'b0; sat = 1'b0;
    repeat (2) cyc();
    ncmp++; if (out !== 4'd5 || wrap !== 1'b0) begin nerr++; $display("FAIL step_zero: got out=%0d wrap=%b want out=5 wrap=0", out, wrap); end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 4'd0; cyc();
    load = 1'b0; en = 1'b1; down = 1'b0; step = 2'd1; sat = 1'b0;
    repeat (5) cyc();
    ncmp++; if (out !== 4'd5) begin nerr++; $display("FAIL mid_count: got %0d want 5", out); end
    nrst = 1'b0;
    cyc();
    ncmp++; if (out !== 4'd0 || wrap !== 1'b0 || at_min !== 1'b1) begin nerr++; $display("FAIL mid_reset: got out=%0d wrap=%b at_min=%b want 0 0 1", out, wrap, at_min); end
    nrst = 1'b1; en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      nrst     = ($urandom_range(0, 29) != 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      down     = 1'($urandom);
      sat      = 1'($urandom);
      step     = 2'($urandom);
      cyc();
      ncmp++;
      if (out !== 4'(m_out) || wrap !== m_wrap || at_max !== (m_out == MAXV) || at_min !== (m_out == 0)) begin
        nerr++;
        $display("FAIL random[%0d]: got out=%0d wrap=%b max=%b min=%b want out=%0d wrap=%b", i, out, wrap, at_max, at_min, m_out, m_wrap);
      end
    end
    nrst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_default();
    int prev;
    int wraps;
    wraps = 0;
    nrst_d = 1'b0; cyc();
    ncmp++; if (out_d !== 4'd0 || at_min_d !== 1'b1 || at_max_d !== 1'b0) begin nerr++; $display("FAIL def_reset: got out=%0d min=%b max=%b want 0 1 0", out_d, at_min_d, at_max_d); end
    nrst_d = 1'b1; en_d = 1'b1; step_d = 2'd1; down_d = 1'b0; sat_d = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prev = int'(out_d);
      cyc();
      if (wrap_d === 1'b1) wraps++;
      ncmp++;
      if (out_d !== 4'((prev + 1) % 16) || wrap_d !== (prev == 15)) begin
        nerr++;
        $display("FAIL def_step[%0d]: got out=%0d wrap=%b want out=%0d wrap=%b", i, out_d, wrap_d, (prev + 1) % 16, prev == 15);
      end
    end
    ncmp++; if (out_d !== 4'd0) begin nerr++; $display("FAIL def_final: got %0d want 0", out_d); end
    ncmp++; if (wraps != 1) begin nerr++; $display("FAIL def_wrap_count: got %0d want 1", wraps); end
    en_d = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; down = 1'b0; sat = 1'b0; load = 1'b0; step = '0; load_val = '0;
    nrst_d = 1'b0; en_d = 1'b0; down_d = 1'b0; sat_d = 1'b0; load_d = 1'b0; step_d = '0; load_val_d = '0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_step_zero();
    test_reset_mid();
    test_random();
    test_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
